// File: rtl/nand_op_sequencer.sv
// Steps SPI-NAND reset/read/program/erase operations through mem_command, one opcode
// at a time, and polls the status register until the device is idle, failed or out of budget.
module nand_op_sequencer #(
   parameter int unsigned MAX_POLLS    = 1000,
   parameter int unsigned POLL_GAP     = 64,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [1:0]  i_Op,
   input  logic [23:0] i_Op_Row,
   input  logic [12:0] i_Op_Col,
   input  logic        i_Op_Valid,
   output logic        o_Op_Ready,
   output logic        o_Done,
   output logic [1:0]  o_Status,
   output logic [7:0]  o_Status_Byte,
   output logic [7:0]  o_Command,
   output logic [23:0] o_Addr_Data,
   output logic        o_CM_DV,
   input  logic        i_CM_Ready,
   input  logic [7:0]  i_RX_Feature_Byte,
   input  logic        i_RX_Feature_DV
);

   localparam int unsigned PCNT_RAW = $clog2(MAX_POLLS + 1);
   localparam int unsigned PCNT_W   = (PCNT_RAW < 1) ? 1 : PCNT_RAW;
   localparam int unsigned TMR_MAX  = (BUSY_TIMEOUT > POLL_GAP) ? BUSY_TIMEOUT : POLL_GAP;
   localparam int unsigned TMR_RAW  = $clog2(TMR_MAX + 1);
   localparam int unsigned TMR_W    = (TMR_RAW < 1) ? 1 : TMR_RAW;

   localparam logic [1:0] OP_RESET   = 2'b00;
   localparam logic [1:0] OP_READ    = 2'b01;
   localparam logic [1:0] OP_PROGRAM = 2'b10;
   localparam logic [1:0] OP_ERASE   = 2'b11;

   localparam logic [7:0] OPC_WREN        = 8'h06;
   localparam logic [7:0] OPC_RESET       = 8'hFF;
   localparam logic [7:0] OPC_PAGE_READ   = 8'h13;
   localparam logic [7:0] OPC_CACHE_READ  = 8'h03;
   localparam logic [7:0] OPC_PROG_LOAD1  = 8'h02;
   localparam logic [7:0] OPC_PROG_EXEC   = 8'h10;
   localparam logic [7:0] OPC_BLOCK_ERASE = 8'hD8;
   localparam logic [7:0] OPC_GET_FEATURE = 8'h0F;

   localparam logic [23:0] POLL_ADDR = 24'h00C000;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_FAIL    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_NO_RESP = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE, S_CHECK, S_GAP, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [23:0]         row_q, row_d;
   logic [12:0]         col_q, col_d;
   logic [1:0]          step_q, step_d;
   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                dv_seen_q, dv_seen_d;
   logic                op_ready_q, op_ready_d;
   logic                done_q, done_d;
   logic [1:0]          status_q, status_d;
   logic [7:0]          status_byte_q, status_byte_d;
   logic [7:0]          command_q, command_d;
   logic [23:0]         addr_q, addr_d;
   logic                cm_dv_q, cm_dv_d;

   logic [7:0]          step_cmd;
   logic [23:0]         step_addr;
   logic                step_poll;
   logic                step_last;
   logic                fail_bit;
   logic                cap_window;

   // Step table: opcode, address and role of the current step of the latched op
   always_comb begin
      step_cmd  = OPC_GET_FEATURE;
      step_addr = POLL_ADDR;
      step_poll = 1'b1;
      step_last = 1'b1;
      fail_bit  = 1'b0;
      case (op_q)
         OP_RESET: begin
            if (step_q == 2'd0) begin
               step_cmd  = OPC_RESET;
               step_addr = 24'h0;
               step_poll = 1'b0;
               step_last = 1'b0;
            end
         end
         OP_READ: begin
            case (step_q)
               2'd0: begin
                  step_cmd  = OPC_PAGE_READ;
                  step_addr = row_q;
                  step_poll = 1'b0;
                  step_last = 1'b0;
               end
               2'd1: step_last = 1'b0;
               default: begin
                  step_cmd  = OPC_CACHE_READ;
                  step_addr = {11'b0, col_q};
                  step_poll = 1'b0;
               end
            endcase
         end
         OP_PROGRAM: begin
            fail_bit = status_byte_q[3];
            case (step_q)
               2'd0: begin
                  step_cmd  = OPC_WREN;
                  step_addr = 24'h0;
                  step_poll = 1'b0;
                  step_last = 1'b0;
               end
               2'd1: begin
                  step_cmd  = OPC_PROG_LOAD1;
                  step_addr = {11'b0, col_q};
                  step_poll = 1'b0;
                  step_last = 1'b0;
               end
               2'd2: begin
                  step_cmd  = OPC_PROG_EXEC;
                  step_addr = row_q;
                  step_poll = 1'b0;
                  step_last = 1'b0;
               end
               default: ;
            endcase
         end
         OP_ERASE: begin
            fail_bit = status_byte_q[2];
            case (step_q)
               2'd0: begin
                  step_cmd  = OPC_WREN;
                  step_addr = 24'h0;
                  step_poll = 1'b0;
                  step_last = 1'b0;
               end
               2'd1: begin
                  step_cmd  = OPC_BLOCK_ERASE;
                  step_addr = row_q;
                  step_poll = 1'b0;
                  step_last = 1'b0;
               end
               default: ;
            endcase
         end
      endcase
   end

   assign cap_window = step_poll &&
                       (state_q == S_ISSUE || state_q == S_WAIT_BUSY || state_q == S_WAIT_IDLE);

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      row_d         = row_q;
      col_d         = col_q;
      step_d        = step_q;
      pcnt_d        = pcnt_q;
      tmr_d         = tmr_q;
      dv_seen_d     = dv_seen_q;
      status_d      = status_q;
      status_byte_d = status_byte_q;
      command_d     = command_q;
      addr_d        = addr_q;
      cm_dv_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_Op_Valid) begin
               op_d          = i_Op;
               row_d         = i_Op_Row;
               col_d         = i_Op_Col;
               step_d        = 2'd0;
               pcnt_d        = '0;
               status_byte_d = 8'h00;
               dv_seen_d     = 1'b0;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (i_CM_Ready) begin
               cm_dv_d   = 1'b1;
               command_d = step_cmd;
               addr_d    = step_addr;
               tmr_d     = '0;
               state_d   = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (!i_CM_Ready) begin
               state_d = S_WAIT_IDLE;
            end else if (tmr_q == TMR_W'(BUSY_TIMEOUT)) begin
               status_d = ST_NO_RESP;
               state_d  = S_DONE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (i_CM_Ready) begin
               if (step_poll) begin
                  state_d = S_CHECK;
               end else begin
                  step_d = step_q + 2'd1;
                  if (step_last) begin
                     status_d = ST_OK;
                     state_d  = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end
         end
         S_CHECK: begin
            dv_seen_d = 1'b0;
            if (!dv_seen_q) begin
               status_d = ST_NO_RESP;
               state_d  = S_DONE;
            end else if (!status_byte_q[0]) begin
               if (fail_bit) begin
                  status_d = ST_FAIL;
                  state_d  = S_DONE;
               end else begin
                  step_d = step_q + 2'd1;
                  if (step_last) begin
                     status_d = ST_OK;
                     state_d  = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end else if (pcnt_q < PCNT_W'(MAX_POLLS)) begin
               pcnt_d  = pcnt_q + PCNT_W'(1);
               tmr_d   = '0;
               state_d = S_GAP;
            end else begin
               status_d = ST_TIMEOUT;
               state_d  = S_DONE;
            end
         end
         S_GAP: begin
            if (32'(tmr_q) + 32'd1 >= POLL_GAP) begin
               state_d = S_ISSUE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Feature bytes only count while a poll command is in flight
      if (cap_window && i_RX_Feature_DV) begin
         status_byte_d = i_RX_Feature_Byte;
         dv_seen_d     = 1'b1;
      end

      op_ready_d = (state_d == S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q       <= S_IDLE;
         op_q          <= 2'b00;
         row_q         <= 24'h0;
         col_q         <= 13'h0;
         step_q        <= 2'd0;
         pcnt_q        <= '0;
         tmr_q         <= '0;
         dv_seen_q     <= 1'b0;
         op_ready_q    <= 1'b1;
         done_q        <= 1'b0;
         status_q      <= 2'b00;
         status_byte_q <= 8'h00;
         command_q     <= 8'h00;
         addr_q        <= 24'h0;
         cm_dv_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         row_q         <= row_d;
         col_q         <= col_d;
         step_q        <= step_d;
         pcnt_q        <= pcnt_d;
         tmr_q         <= tmr_d;
         dv_seen_q     <= dv_seen_d;
         op_ready_q    <= op_ready_d;
         done_q        <= done_d;
         status_q      <= status_d;
         status_byte_q <= status_byte_d;
         command_q     <= command_d;
         addr_q        <= addr_d;
         cm_dv_q       <= cm_dv_d;
      end
   end

   assign o_Op_Ready    = op_ready_q;
   assign o_Done        = done_q;
   assign o_Status      = status_q;
   assign o_Status_Byte = status_byte_q;
   assign o_Command     = command_q;
   assign o_Addr_Data   = addr_q;
   assign o_CM_DV       = cm_dv_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer with a small reactive mem_command model
// that returns feature bytes from a queue.
module tb_nand_op_sequencer;

   localparam int unsigned MAX_POLLS    = 4;
   localparam int unsigned POLL_GAP     = 4;
   localparam int unsigned BUSY_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  op_sel = 2'b00;
   logic [23:0] op_row = 24'h0;
   logic [12:0] op_col = 13'h0;
   logic        op_valid = 1'b0;
   logic        o_Op_Ready, o_Done, o_CM_DV;
   logic [1:0]  o_Status;
   logic [7:0]  o_Status_Byte, o_Command;
   logic [23:0] o_Addr_Data;
   logic        cm_ready = 1'b1;
   logic [7:0]  fbyte = 8'h00;
   logic        fdv = 1'b0;

   nand_op_sequencer #(
      .MAX_POLLS(MAX_POLLS), .POLL_GAP(POLL_GAP), .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Op(op_sel), .i_Op_Row(op_row), .i_Op_Col(op_col),
      .i_Op_Valid(op_valid), .o_Op_Ready(o_Op_Ready), .o_Done(o_Done), .o_Status(o_Status),
      .o_Status_Byte(o_Status_Byte), .o_Command(o_Command), .o_Addr_Data(o_Addr_Data),
      .o_CM_DV(o_CM_DV), .i_CM_Ready(cm_ready), .i_RX_Feature_Byte(fbyte),
      .i_RX_Feature_DV(fdv)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int acc_cnt  = 0;
   int done_cnt = 0;
   int viol_b2b = 0;
   int viol_rdy = 0;
   int done_cyc = 0;
   bit prev_dv  = 1'b0;

   bit stuck    = 1'b0;
   bit feat_en  = 1'b1;
   bit stray_en = 1'b0;
   bit is_poll  = 1'b0;
   logic [7:0]  fdef = 8'h00;
   logic [7:0]  feat_q[$];
   logic [31:0] cmd_log[$];
   logic [31:0] exp_q[$];
   int          dv_cyc[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Cycle counter plus protocol monitors on the pre-edge values
   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         if (o_CM_DV && prev_dv) viol_b2b++;
         if (o_CM_DV && !cm_ready) viol_rdy++;
         if (o_Op_Ready && op_valid) acc_cnt++;
         if (o_Done) done_cnt++;
      end
      prev_dv = o_CM_DV;
   end

   // mem_command model: busy for three cycles after each strobe, feature byte mid-busy
   initial begin : mem_model
      forever begin
         @(posedge clk); #1;
         if (!rst && o_CM_DV) begin
            cmd_log.push_back({o_Command, o_Addr_Data});
            dv_cyc.push_back(cyc);
            if (!stuck) begin
               is_poll = (o_Command == 8'h0F);
               @(posedge clk); #1; cm_ready = 1'b0;
               @(posedge clk); #1;
               if (is_poll && feat_en) begin
                  fbyte = (feat_q.size() > 0) ? feat_q.pop_front() : fdef;
                  fdv   = 1'b1;
               end else if (!is_poll && stray_en) begin
                  fbyte = 8'hFF;
                  fdv   = 1'b1;
               end
               @(posedge clk); #1; fdv = 1'b0;
               @(posedge clk); #1; cm_ready = 1'b1;
            end
         end
      end
   end

   task automatic clear_logs();
      cmd_log.delete();
      dv_cyc.delete();
      exp_q.delete();
      feat_q.delete();
   endtask

   task automatic start_op(input logic [1:0] op, input logic [23:0] row, input logic [12:0] col);
      op_sel = op; op_row = row; op_col = col; op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      check_eq("ready_low_after_accept", 32'(o_Op_Ready), 32'd0);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (!o_Done && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq({tag, "_done_seen"}, 32'(o_Done), 32'd1);
      done_cyc = cyc;
   endtask

   task automatic check_log(input string tag);
      check_eq({tag, "_cmd_count"}, 32'(cmd_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
         check_eq($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_q[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int d0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(1);
      check_eq("rst_op_ready", 32'(o_Op_Ready), 32'd1);
      check_eq("rst_done", 32'(o_Done), 32'd0);
      check_eq("rst_cm_dv", 32'(o_CM_DV), 32'd0);
      check_eq("rst_status", 32'(o_Status), 32'd0);
      check_eq("rst_status_byte", 32'(o_Status_Byte), 32'd0);
      check_eq("rst_cmd_addr", {o_Command, o_Addr_Data}, 32'd0);

      // ERASE: three busy polls then ready
      clear_logs();
      feat_q.push_back(8'h01); feat_q.push_back(8'h01);
      feat_q.push_back(8'h01); feat_q.push_back(8'h00);
      start_op(2'b11, 24'h000140, 13'h0);
      wait_done("erase", 400);
      check_eq("erase_status", 32'(o_Status), 32'd0);
      check_eq("erase_sbyte", 32'(o_Status_Byte), 32'h00);
      exp_q = '{32'h06000000, 32'hD8000140, 32'h0F00C000, 32'h0F00C000,
                32'h0F00C000, 32'h0F00C000};
      check_log("erase");
      if (dv_cyc.size() >= 4)
         check_eq("poll_spacing", 32'(dv_cyc[3] - dv_cyc[2] >= 4 + POLL_GAP + 1), 32'd1);
      idle(2);
      check_eq("ready_after_done", 32'(o_Op_Ready), 32'd1);

      // PROGRAM: program-fail bit reported
      clear_logs();
      feat_q.push_back(8'h08);
      start_op(2'b10, 24'h000200, 13'h0ABC);
      wait_done("prog", 400);
      check_eq("prog_status", 32'(o_Status), 32'd1);
      check_eq("prog_sbyte", 32'(o_Status_Byte), 32'h08);
      exp_q = '{32'h06000000, 32'h02000ABC, 32'h10000200, 32'h0F00C000};
      check_log("prog");
      idle(2);

      // READ with device stuck busy: poll budget exhausted, no CACHE_READ
      clear_logs();
      fdef = 8'h01;
      start_op(2'b01, 24'h000300, 13'h0010);
      wait_done("rd_to", 400);
      check_eq("rd_to_status", 32'(o_Status), 32'd2);
      check_eq("rd_to_sbyte", 32'(o_Status_Byte), 32'h01);
      exp_q = '{32'h13000300, 32'h0F00C000, 32'h0F00C000, 32'h0F00C000,
                32'h0F00C000, 32'h0F00C000};
      check_log("rd_to");
      idle(2);

      // mem_command never goes busy
      clear_logs();
      stuck = 1'b1;
      start_op(2'b00, 24'h0, 13'h0);
      wait_done("stuck", 100);
      check_eq("stuck_status", 32'(o_Status), 32'd3);
      d0 = (dv_cyc.size() > 0) ? dv_cyc[0] : 0;
      check_eq("stuck_latency", 32'(done_cyc - d0), 32'(BUSY_TIMEOUT + 1));
      stuck = 1'b0;
      idle(2);

      // Poll completes without any feature byte
      clear_logs();
      feat_en = 1'b0;
      start_op(2'b00, 24'h0, 13'h0);
      wait_done("nodv", 200);
      check_eq("nodv_status", 32'(o_Status), 32'd3);
      exp_q = '{32'hFF000000, 32'h0F00C000};
      check_log("nodv");
      feat_en = 1'b1;
      idle(2);

      // Reset in the poll gap of a READ, then a clean RESET op
      clear_logs();
      fdef = 8'h01;
      start_op(2'b01, 24'h000777, 13'h0001);
      for (int i = 0; i < 100 && cmd_log.size() < 2; i++) begin
         @(posedge clk); #1;
      end
      check_eq("gap_poll_issued", 32'(cmd_log.size()), 32'd2);
      repeat (7) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_eq("arst_op_ready", 32'(o_Op_Ready), 32'd1);
      check_eq("arst_status_byte", 32'(o_Status_Byte), 32'd0);
      check_eq("arst_cmd_addr", {o_Command, o_Addr_Data}, 32'd0);
      check_eq("arst_dv_done", {30'd0, o_CM_DV, o_Done}, 32'd0);
      d0 = done_cnt;
      idle(2);
      rst = 1'b0;
      idle(20);
      check_eq("arst_no_done", 32'(done_cnt - d0), 32'd0);
      clear_logs();
      fdef = 8'h00;
      feat_q.push_back(8'h00);
      start_op(2'b00, 24'h0, 13'h0);
      wait_done("post_rst", 200);
      check_eq("post_rst_status", 32'(o_Status), 32'd0);
      exp_q = '{32'hFF000000, 32'h0F00C000};
      check_log("post_rst");
      idle(2);

      // Valid held high across two READs with stray feature bytes on non-poll steps
      clear_logs();
      fdef = 8'h20;
      stray_en = 1'b1;
      d0 = acc_cnt;
      op_sel = 2'b01; op_row = 24'h000055; op_col = 13'h0007; op_valid = 1'b1;
      idle(1);
      wait_done("hold1", 300);
      idle(1);
      wait_done("hold2", 300);
      op_valid = 1'b0;
      check_eq("hold_status", 32'(o_Status), 32'd0);
      check_eq("hold_sbyte", 32'(o_Status_Byte), 32'h20);
      idle(5);
      check_eq("hold_accepts", 32'(acc_cnt - d0), 32'd2);
      exp_q = '{32'h13000055, 32'h0F00C000, 32'h03000007,
                32'h13000055, 32'h0F00C000, 32'h03000007};
      check_log("hold");
      stray_en = 1'b0;

      check_eq("dv_back_to_back", 32'(viol_b2b), 32'd0);
      check_eq("dv_while_busy", 32'(viol_rdy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
